// File: rtl/cpu_run_pkg.sv
// Shared types for the CPU run controller: FSM states, run modes and mode decode.
package cpu_run_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    RUN,
    STEP_WAIT,
    STEP,
    DONE
  } run_state_e;

  typedef enum logic [1:0] {
    MODE_FREE = 2'b00,
    MODE_STEP = 2'b01,
    MODE_HALT = 2'b10
  } run_mode_e;

  // Raw mode encoding 2'b11 has no meaning of its own and runs as free-run.
  function automatic run_mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'b01:   return MODE_STEP;
      2'b10:   return MODE_HALT;
      default: return MODE_FREE;
    endcase
  endfunction

endpackage

// File: rtl/cpu_halt_detect.sv
// Halt detector: flags a halt when the fetch PC has stayed unchanged for
// HALT_STABLE consecutive enabled cycles.
module cpu_halt_detect #(
  parameter int unsigned PC_WIDTH    = 64,
  parameter int unsigned HALT_STABLE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                en,
  input  logic [PC_WIDTH-1:0] pc,
  output logic                halt
);

  localparam int unsigned SW = $clog2(HALT_STABLE + 1);

  logic [PC_WIDTH-1:0] pc_ref;
  logic [SW-1:0]       stable;
  logic                same;

  assign same = (pc == pc_ref);

  // Halt is raised combinationally on the cycle whose comparison completes the
  // stable run, so the controller can stop on that same edge without an extra
  // enabled cycle.
  assign halt = en && same && (stable == SW'(HALT_STABLE - 1));

  // Reference PC and consecutive-match counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_ref <= '0;
      stable <= '0;
    end else if (clr) begin
      pc_ref <= pc;
      stable <= '0;
    end else if (en) begin
      pc_ref <= pc;
      stable <= same ? stable + 1'b1 : '0;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the pipelined CPU: sequences CPU reset, gates execution
// with a clock enable, counts enabled cycles and stops on budget, halt or step.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 1,
  parameter int unsigned MAX_CYCLES   = 2000,
  parameter int unsigned HALT_STABLE  = 4,
  parameter int unsigned PC_WIDTH     = 64,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic                 step,
  input  logic                 abort,
  input  logic [PC_WIDTH-1:0]  pc,
  output logic                 cpu_reset,
  output logic                 cpu_en,
  output logic                 busy,
  output logic                 done,
  output logic                 halted,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam int unsigned RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  run_state_e         state;
  run_mode_e          mode_q;
  logic [RCW-1:0]     rst_cnt;
  logic [CNT_WIDTH-1:0] next_count;
  logic               budget_hit;
  logic               halt_clr;
  logic               halt_en;
  logic               halt;

  // Halt reference is taken on the last reset cycle; comparisons run only in RUN of halt mode.
  assign halt_clr = (state == RST) && (rst_cnt == '0);
  assign halt_en  = (state == RUN) && (mode_q == MODE_HALT);

  cpu_halt_detect #(
    .PC_WIDTH    (PC_WIDTH),
    .HALT_STABLE (HALT_STABLE)
  ) u_halt (
    .clk   (clk),
    .reset (reset),
    .clr   (halt_clr),
    .en    (halt_en),
    .pc    (pc),
    .halt  (halt)
  );

  // Saturating next cycle count and "this enabled cycle exhausts the budget".
  always_comb begin
    next_count = cycle_count;
    if (cycle_count < CNT_WIDTH'(MAX_CYCLES)) next_count = cycle_count + 1'b1;
    budget_hit = (cycle_count >= CNT_WIDTH'(MAX_CYCLES - 1));
  end

  // Run sequencer with registered outputs; abort overrides every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mode_q      <= MODE_FREE;
      rst_cnt     <= '0;
      cpu_reset   <= 1'b1;
      cpu_en      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else if (abort) begin
      state     <= IDLE;
      cpu_reset <= 1'b1;
      cpu_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      halted    <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RST;
            mode_q      <= decode_mode(mode);
            rst_cnt     <= RCW'(RESET_CYCLES - 1);
            cpu_reset   <= 1'b1;
            cpu_en      <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
          end
        end
        RST: begin
          if (rst_cnt == '0) begin
            cpu_reset <= 1'b0;
            if (mode_q == MODE_STEP) begin
              state <= STEP_WAIT;
            end else begin
              state  <= RUN;
              cpu_en <= 1'b1;
            end
          end else begin
            rst_cnt <= rst_cnt - 1'b1;
          end
        end
        RUN: begin
          cycle_count <= next_count;
          if (halt || budget_hit) begin
            state   <= DONE;
            cpu_en  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            halted  <= halt;
            timeout <= !halt && (mode_q == MODE_HALT);
          end
        end
        STEP_WAIT: begin
          if (step) begin
            state  <= STEP;
            cpu_en <= 1'b1;
          end
        end
        STEP: begin
          cycle_count <= next_count;
          cpu_en      <= 1'b0;
          if (budget_hit) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= STEP_WAIT;
          end
        end
        default: begin
          state     <= IDLE;
          cpu_reset <= 1'b1;
          cpu_en    <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with RESET_CYCLES=3, MAX_CYCLES=20, HALT_STABLE=4.
module tb_cpu_run_ctrl;

  localparam int unsigned PCW = 64;
  localparam int unsigned CW  = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [1:0]     mode;
  logic           step;
  logic           abort;
  logic [PCW-1:0] pc;
  logic           cpu_reset;
  logic           cpu_en;
  logic           busy;
  logic           done;
  logic           halted;
  logic           timeout;
  logic [CW-1:0]  cycle_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .RESET_CYCLES (3),
    .MAX_CYCLES   (20),
    .HALT_STABLE  (4),
    .PC_WIDTH     (PCW),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .step        (step),
    .abort       (abort),
    .pc          (pc),
    .cpu_reset   (cpu_reset),
    .cpu_en      (cpu_en),
    .busy        (busy),
    .done        (done),
    .halted      (halted),
    .timeout     (timeout),
    .cycle_count (cycle_count)
  );

  // Pulse start for one edge; returns at the negedge after the sampling edge.
  task automatic do_start(input logic [1:0] m);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_rst(output int n);
    n = 0;
    while (cpu_reset === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic count_en(output int n);
    n = 0;
    while (cpu_en === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset got %b exp 1", cpu_reset); end
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL rst_cpu_en got %b exp 0", cpu_en); end
    checks++; if ({busy, done, halted, timeout} !== 4'b0000) begin errors++; $display("FAIL rst_flags got %b exp 0000", {busy, done, halted, timeout}); end
    checks++; if (cycle_count !== '0) begin errors++; $display("FAIL rst_count got %0d exp 0", cycle_count); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (cpu_reset !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL idle_outputs got rst=%b busy=%b exp rst=1 busy=0", cpu_reset, busy); end
  endtask

  task automatic test_free_run(input logic [1:0] m, input string tag);
    int nr, ne;
    pc = '0;
    do_start(m);
    checks++; if (busy !== 1'b1 || cycle_count !== '0 || cpu_en !== 1'b0) begin errors++; $display("FAIL %s_start got busy=%b cnt=%0d en=%b exp 1/0/0", tag, busy, cycle_count, cpu_en); end
    wait_rst(nr);
    checks++; if (nr != 3) begin errors++; $display("FAIL %s_reset_cycles got %0d exp 3", tag, nr); end
    count_en(ne);
    checks++; if (ne != 20) begin errors++; $display("FAIL %s_en_cycles got %0d exp 20", tag, ne); end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL %s_done got done=%b busy=%b exp 1/0", tag, done, busy); end
    checks++; if (cycle_count !== 32'd20) begin errors++; $display("FAIL %s_count got %0d exp 20", tag, cycle_count); end
    checks++; if (timeout !== 1'b0 || halted !== 1'b0 || cpu_reset !== 1'b0) begin errors++; $display("FAIL %s_flags got to=%b h=%b rst=%b exp 0/0/0", tag, timeout, halted, cpu_reset); end
  endtask

  // PC advances by 4 per enabled cycle until it reaches 4*plat, then holds.
  task automatic run_halt(input int plat, input int exp_cnt, input logic exp_h, input logic exp_t, input string tag);
    int nr, k;
    pc = '0;
    do_start(2'b10);
    wait_rst(nr);
    k = 1;
    while (cpu_en === 1'b1 && k < 100) begin
      pc = PCW'(4 * ((k < plat) ? k : plat));
      @(negedge clk);
      k++;
    end
    checks++; if (k - 1 != exp_cnt) begin errors++; $display("FAIL %s_en_cycles got %0d exp %0d", tag, k - 1, exp_cnt); end
    checks++; if (cycle_count !== CW'(exp_cnt)) begin errors++; $display("FAIL %s_count got %0d exp %0d", tag, cycle_count, exp_cnt); end
    checks++; if (halted !== exp_h) begin errors++; $display("FAIL %s_halted got %b exp %b", tag, halted, exp_h); end
    checks++; if (timeout !== exp_t) begin errors++; $display("FAIL %s_timeout got %b exp %b", tag, timeout, exp_t); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s_done got %b exp 1", tag, done); end
  endtask

  task automatic test_halt;
    run_halt(10, 14, 1'b1, 1'b0, "halt_plateau");
    run_halt(1000, 20, 1'b0, 1'b1, "halt_timeout");
    run_halt(16, 20, 1'b1, 1'b0, "halt_coincide");
  endtask

  task automatic test_single_step;
    int nr, ne, adj;
    logic prev;
    pc = '0;
    do_start(2'b01);
    wait_rst(nr);
    checks++; if (nr != 3 || busy !== 1'b1 || cpu_en !== 1'b0) begin errors++; $display("FAIL step_wait got rstc=%0d busy=%b en=%b exp 3/1/0", nr, busy, cpu_en); end
    ne = 0;
    for (int s = 0; s < 3; s++) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      if (cpu_en === 1'b1) ne++;
      for (int w = 0; w < 4; w++) begin
        @(negedge clk);
        if (cpu_en === 1'b1) ne++;
      end
    end
    checks++; if (ne != 3) begin errors++; $display("FAIL step_pulses got %0d exp 3", ne); end
    checks++; if (cycle_count !== 32'd3 || done !== 1'b0) begin errors++; $display("FAIL step_count got cnt=%0d done=%b exp 3/0", cycle_count, done); end
    // Held step: one enabled cycle per two clocks until the budget ends the run.
    step = 1'b1;
    ne   = 0;
    adj  = 0;
    prev = 1'b0;
    for (int c = 0; c < 100 && done !== 1'b1; c++) begin
      @(negedge clk);
      if (cpu_en === 1'b1) ne++;
      if (cpu_en === 1'b1 && prev === 1'b1) adj++;
      prev = cpu_en;
    end
    step = 1'b0;
    checks++; if (ne != 17) begin errors++; $display("FAIL step_held_pulses got %0d exp 17", ne); end
    checks++; if (adj != 0) begin errors++; $display("FAIL step_held_adjacent got %0d exp 0", adj); end
    checks++; if (done !== 1'b1 || cycle_count !== 32'd20 || timeout !== 1'b0) begin errors++; $display("FAIL step_budget got done=%b cnt=%0d to=%b exp 1/20/0", done, cycle_count, timeout); end
  endtask

  task automatic test_async_reset;
    int nr, g;
    pc = '0;
    do_start(2'b00);
    wait_rst(nr);
    g = 0;
    while (cycle_count !== 32'd7 && g < 50) begin
      @(negedge clk);
      g++;
    end
    checks++; if (cpu_en !== 1'b1 || cycle_count !== 32'd7) begin errors++; $display("FAIL arst_reach got en=%b cnt=%0d exp 1/7", cpu_en, cycle_count); end
    #2 reset = 1'b1;
    #1;
    checks++; if (cpu_reset !== 1'b1 || cpu_en !== 1'b0) begin errors++; $display("FAIL arst_cpu got rst=%b en=%b exp 1/0", cpu_reset, cpu_en); end
    checks++; if ({busy, done, halted, timeout} !== 4'b0000 || cycle_count !== '0) begin errors++; $display("FAIL arst_flags got %b cnt=%0d exp 0000/0", {busy, done, halted, timeout}, cycle_count); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_abort_done;
    int nr, ne, n2;
    pc = '0;
    do_start(2'b00);
    wait_rst(nr);
    // start while running must be ignored
    for (int i = 0; i < 5; i++) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    count_en(ne);
    checks++; if (ne + 6 != 20 || cycle_count !== 32'd20 || done !== 1'b1) begin errors++; $display("FAIL ignore_start got en=%0d cnt=%0d done=%b exp 20/20/1", ne + 6, cycle_count, done); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (done !== 1'b0 || cycle_count !== 32'd20) begin errors++; $display("FAIL abort_done got done=%b cnt=%0d exp 0/20", done, cycle_count); end
    checks++; if (cpu_reset !== 1'b1 || busy !== 1'b0 || cpu_en !== 1'b0) begin errors++; $display("FAIL abort_idle got rst=%b busy=%b en=%b exp 1/0/0", cpu_reset, busy, cpu_en); end
    // step in IDLE must be ignored
    step = 1'b1;
    @(negedge clk);
    @(negedge clk);
    step = 1'b0;
    checks++; if (cpu_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_step got en=%b busy=%b exp 0/0", cpu_en, busy); end
    n2 = 0;
  endtask

  task automatic test_back_to_back;
    int nr, ne;
    // Previous run ended in DONE with halted set; restart straight from DONE.
    run_halt(10, 14, 1'b1, 1'b0, "pre_restart");
    checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL done_cpu_reset got %b exp 0", cpu_reset); end
    do_start(2'b00);
    checks++; if (done !== 1'b0 || halted !== 1'b0 || cycle_count !== '0) begin errors++; $display("FAIL restart_clear got done=%b h=%b cnt=%0d exp 0/0/0", done, halted, cycle_count); end
    wait_rst(nr);
    checks++; if (nr != 3) begin errors++; $display("FAIL restart_reset_cycles got %0d exp 3", nr); end
    count_en(ne);
    checks++; if (ne != 20 || cycle_count !== 32'd20 || done !== 1'b1) begin errors++; $display("FAIL restart_run got en=%0d cnt=%0d done=%b exp 20/20/1", ne, cycle_count, done); end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    mode  = 2'b00;
    step  = 1'b0;
    abort = 1'b0;
    pc    = '0;
    test_reset;
    test_free_run(2'b00, "free");
    test_free_run(2'b11, "mode11");
    test_halt;
    test_single_step;
    test_async_reset;
    test_abort_done;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule
